spi_frame_rx: RTL and testbench
===============================

# spi_frame_rx

Serial-to-parallel frame receiver for the far end of the generator and pult shift-register links. It oversamples the master's `sclk`/`sdo`/`lock` lines on the local `clk` and checks the frame length on each `lock` pulse. Good frames are latched onto a parallel output. The last applied word is shifted back on `sdi` for master readback. A link watchdog forces a safe default word when frames stop arriving.

## Interface
- `WIDTH`, 16: frame length in bits (24 for pult, 16 for generator).
- `DEFAULT`, 16'h0824: value of `data_out` after reset, `sclr` and timeout; WIDTH bits.
- `TIMEOUT`, 720_000: clk cycles without a good frame before timeout (10 ms at 72 MHz); ≥2.
- `INVERT_SDO`, 0: 1 = invert `sdo` before sampling (pult link drives inverted data).
- `clk`  in  1  system clock.
- `aclr`  in  1  reset, asynchronous, active-high.
- `sclr`  in  1  synchronous clear, same effect as `aclr`.
- `sclk`  in  1  serial clock from master, asynchronous to `clk`, idle low.
- `sdo`  in  1  serial data from master, asynchronous.
- `lock`  in  1  frame latch strobe from master, asynchronous, active-high.
- `sdi`  out  1  readback data to master.
- `data_out`  out  WIDTH  last applied word.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates from a good frame.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.
- `timeout`  out  1  level; watchdog expired, cleared by the next good frame.

## Operation
- Input conditioning: `sclk`, `sdo` and `lock` each pass through a 2-FF synchronizer plus one history FF. Rise = sync & ~hist.
- Protocol: the master changes `sdo` while `sclk` is low. The receiver samples the synchronized `sdo` on each `sclk` rise, MSB first. `lock` rises with `sclk` low after the last bit.
- Shift: on an `sclk` rise with synchronized `lock` low, `rx_sh <= {rx_sh[WIDTH-2:0], sdo_s}`. `bit_cnt` increments and saturates at WIDTH+1. `sclk` rises while `lock` is high are ignored.
- States:
  - IDLE: `bit_cnt`=0.
  - SHIFT: 0<`bit_cnt`≤WIDTH.
  - OVER: `bit_cnt`=WIDTH+1.
  - An `sclk` rise moves IDLE to SHIFT, SHIFT stays in SHIFT, and SHIFT moves to OVER on the (WIDTH+1)th bit.
  - Any `lock` rise returns to IDLE.
- `lock` rise with `bit_cnt`==WIDTH (good frame):
  - `data_out <= rx_sh`; `tx_sh <= rx_sh`.
  - `data_valid` pulses; watchdog counter clears; `timeout` clears.
- `lock` rise with `bit_cnt`≠WIDTH (including 0 and OVER): `frame_err` pulses; `data_out`, `tx_sh` and `timeout` are unchanged.
- Readback: `sdi = tx_sh[WIDTH-1]` (registered). After each accepted `sclk` rise, `tx_sh <= {tx_sh[WIDTH-2:0], 1'b0}`. Over the next frame the master receives the word currently applied.
- Watchdog:
  - 32-bit counter increments every clk and saturates.
  - Reaching TIMEOUT-1 sets `timeout` and loads DEFAULT into `data_out` and `tx_sh`. No `data_valid` pulse is generated.
  - An in-progress frame is not affected.
- Reset/`sclr`:
  - `data_out`=DEFAULT, `tx_sh`=DEFAULT, so `sdi`=DEFAULT[WIDTH-1].
  - `rx_sh`=0, `bit_cnt`=0, watchdog counter=0.
  - `data_valid`=0, `frame_err`=0, `timeout`=0.
  - Synchronizer and history FFs = 0, so a line already high does not create an edge after reset.
- Reset or `sclr` mid-frame discards the partial frame. The next frame must be complete to be accepted.

## Timing
- Pin edge to internal rise detect: 3 clk (2 sync + 1 edge register).
- `lock` pin rise to `data_out`/`data_valid` update: 4 clk; `data_valid` is high for exactly 1 clk.
- `sclk` pin rise to new `sdi` value: 4 clk.
- The master must hold `sclk` high ≥3 clk and low ≥3 clk. `sdo` must be stable from 3 clk before to 3 clk after each `sclk` rise. `lock` must be high ≥3 clk. A master with CLK_DIV 18 satisfies this.
- `lock` rise and `sclk` rise detected in the same clk: `lock` is processed and the `sclk` edge is discarded.
- Good-frame accept and watchdog expiry in the same clk: the good frame wins; `data_out`=`rx_sh` and `timeout` stays 0.
- `sclr` has priority over all events in its cycle.

## Test plan
- Reset, then idle lines.
  - Required: `data_out`=16'h0824, `sdi`=0, `timeout`=0.
  - Required: no `data_valid` or `frame_err` pulse.
- Send 16'hA5C3 MSB first, then `lock`.
  - Required: `data_out`=16'hA5C3 and one `data_valid` pulse, 4 clk after the `lock` rise.
  - Next frame 16'h1234: `sdi` bits captured on the master side equal 16'hA5C3.
- Send 15 bits, then `lock`; repeat with 17 bits.
  - Required: a `frame_err` pulse each time; `data_out` holds its previous value.
  - A following good 16-bit frame is accepted.
- No frames for TIMEOUT clk after a good frame of 16'hFFFF.
  - Required: `timeout`=1 and `data_out`=16'h0824 at cycle TIMEOUT-1.
  - A subsequent good frame 16'h00FF clears `timeout` and sets `data_out`=16'h00FF.
- INVERT_SDO=1, WIDTH=24, pin data ~24'h123456.
  - Required: `data_out`=24'h123456.
- Assert `aclr` after 8 bits of a frame, release, then send a full frame 16'h5A5A.
  - Required: `data_out`=16'h0824 during reset; 16'h5A5A is accepted with no `frame_err`.

Source files
------------

// File: rtl/spi_frame_rx_if.sv
// Serial link and parallel result bundle between a shift-register master and spi_frame_rx.
// The master modport drives the serial lines; the slave modport is the receiver.
interface spi_frame_rx_if #(
    parameter int WIDTH = 16
);
    logic             sclk;
    logic             sdo;
    logic             lock;
    logic             sdi;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             frame_err;
    logic             timeout;

    modport master (
        output sclk, sdo, lock,
        input  sdi, data_out, data_valid, frame_err, timeout
    );

    modport slave (
        input  sclk, sdo, lock,
        output sdi, data_out, data_valid, frame_err, timeout
    );
endinterface

// File: rtl/spi_frame_rx.sv
// Oversampling serial frame receiver: checks frame length on each lock pulse, applies good
// frames to a parallel word, shifts the applied word back on sdi, and falls back on a watchdog.
module spi_frame_rx #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] DEFAULT    = WIDTH'(16'h0824),
    parameter int unsigned      TIMEOUT    = 720_000,
    parameter bit               INVERT_SDO = 1'b0
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          sclr,
    spi_frame_rx_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [31:0]      WD_HIT   = 32'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_OVER
    } state_t;

    // Per line: [0] first sync FF, [1] second sync FF, [2] history / alignment FF.
    typedef struct packed {
        logic [2:0] sclk;
        logic [2:0] sdo;
        logic [2:0] lock;
        logic       sclk_rise;
        logic       lock_rise;
    } sync_t;

    typedef struct packed {
        logic [WIDTH-1:0] rx_sh;
        logic [WIDTH-1:0] tx_sh;
        logic [WIDTH-1:0] data_out;
        logic [31:0]      wd_cnt;
        logic             data_valid;
        logic             frame_err;
        logic             timeout;
    } dp_t;

    localparam dp_t DP_RST = '{
        rx_sh:      '0,
        tx_sh:      DEFAULT,
        data_out:   DEFAULT,
        wd_cnt:     '0,
        data_valid: 1'b0,
        frame_err:  1'b0,
        timeout:    1'b0
    };

    sync_t            r_sync;
    dp_t              r_dp;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic             w_sdo_pin;
    logic             w_shift_en;
    logic             w_good;
    logic             w_bad;
    logic             w_wd_hit;

    assign w_sdo_pin = bus.sdo ^ INVERT_SDO;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_sync <= '0;
        end else if (sclr) begin
            r_sync <= '0;
        end else begin
            // NOTE: non-blocking so each stage samples the value its predecessor held before the edge.
            r_sync.sclk      <= {r_sync.sclk[1:0], bus.sclk};
            r_sync.sdo       <= {r_sync.sdo[1:0], w_sdo_pin};
            r_sync.lock      <= {r_sync.lock[1:0], bus.lock};
            r_sync.sclk_rise <= r_sync.sclk[1] & ~r_sync.sclk[2];
            r_sync.lock_rise <= r_sync.lock[1] & ~r_sync.lock[2];
        end
    end

    // A lock rise in the same cycle as an sclk rise wins; the sclk edge is dropped.
    assign w_shift_en = r_sync.sclk_rise & ~r_sync.lock[2] & ~r_sync.lock_rise;
    assign w_wd_hit   = (r_dp.wd_cnt == WD_HIT);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
        end else if (sclr) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no branch can infer a latch.
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_good        = 1'b0;
        w_bad         = 1'b0;
        if (r_sync.lock_rise) begin
            w_state_nxt   = S_IDLE;
            w_bit_cnt_nxt = '0;
            if (r_state == S_SHIFT && r_bit_cnt == CNT_FULL) begin
                w_good = 1'b1;
            end else begin
                w_bad = 1'b1;
            end
        end else if (w_shift_en) begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt   = S_SHIFT;
                    w_bit_cnt_nxt = CNT_W'(1);
                end
                S_SHIFT: begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == CNT_FULL) begin
                        w_state_nxt = S_OVER;
                    end
                end
                default: begin
                    w_state_nxt = S_OVER;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_dp <= DP_RST;
        end else if (sclr) begin
            r_dp <= DP_RST;
        end else begin
            r_dp.data_valid <= w_good;
            r_dp.frame_err  <= w_bad;
            if (r_dp.wd_cnt != '1) begin
                r_dp.wd_cnt <= r_dp.wd_cnt + 32'd1;
            end
            if (w_shift_en) begin
                r_dp.rx_sh <= {r_dp.rx_sh[WIDTH-2:0], r_sync.sdo[2]};
            end
            // A good frame outranks a watchdog expiry landing in the same cycle.
            if (w_good) begin
                r_dp.data_out <= r_dp.rx_sh;
                r_dp.tx_sh    <= r_dp.rx_sh;
                r_dp.wd_cnt   <= '0;
                r_dp.timeout  <= 1'b0;
            end else if (w_wd_hit) begin
                r_dp.data_out <= DEFAULT;
                r_dp.tx_sh    <= DEFAULT;
                r_dp.timeout  <= 1'b1;
            end else if (w_shift_en) begin
                r_dp.tx_sh <= {r_dp.tx_sh[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign bus.sdi        = r_dp.tx_sh[WIDTH-1];
    assign bus.data_out   = r_dp.data_out;
    assign bus.data_valid = r_dp.data_valid;
    assign bus.frame_err  = r_dp.frame_err;
    assign bus.timeout    = r_dp.timeout;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: a 16-bit link and a 24-bit inverted-sdo link driven like a CLK_DIV 18
// master, compared against a frame-level model of the applied word and its readback.
module tb_spi_frame_rx;

    localparam int          TO_A  = 3000;
    localparam int          TO_B  = 60000;
    localparam int          H     = 9;
    localparam logic [15:0] DEF_A = 16'h0824;
    localparam logic [23:0] DEF_B = 24'h000824;

    logic clk  = 1'b0;
    logic aclr = 1'b1;
    logic sclr = 1'b0;

    always #5 clk = ~clk;

    spi_frame_rx_if #(.WIDTH(16)) bus_a ();
    spi_frame_rx_if #(.WIDTH(24)) bus_b ();

    spi_frame_rx #(.WIDTH(16), .DEFAULT(DEF_A), .TIMEOUT(TO_A), .INVERT_SDO(1'b0)) dut_a (
        .clk  (clk),
        .aclr (aclr),
        .sclr (sclr),
        .bus  (bus_a.slave)
    );

    spi_frame_rx #(.WIDTH(24), .DEFAULT(DEF_B), .TIMEOUT(TO_B), .INVERT_SDO(1'b1)) dut_b (
        .clk  (clk),
        .aclr (aclr),
        .sclr (sclr),
        .bus  (bus_b.slave)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] applied [2];
    bit          rb_ok   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int wid(input bit sel);
        return sel ? 24 : 16;
    endfunction

    function automatic logic [31:0] deflt(input bit sel);
        return sel ? 32'(DEF_B) : 32'(DEF_A);
    endfunction

    function automatic logic [31:0] rd_data(input bit sel);
        return sel ? 32'(bus_b.data_out) : 32'(bus_a.data_out);
    endfunction

    function automatic logic rd_dv(input bit sel);
        return sel ? bus_b.data_valid : bus_a.data_valid;
    endfunction

    function automatic logic rd_fe(input bit sel);
        return sel ? bus_b.frame_err : bus_a.frame_err;
    endfunction

    function automatic logic rd_sdi(input bit sel);
        return sel ? bus_b.sdi : bus_a.sdi;
    endfunction

    function automatic logic rd_to(input bit sel);
        return sel ? bus_b.timeout : bus_a.timeout;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            applied[s] = deflt(s[0]);
            rb_ok[s]   = 1'b1;
        end
    endtask

    task automatic drive(input bit sel, input logic sclk_v, input logic sdo_v, input logic lock_v);
        if (sel) begin
            bus_b.sclk = sclk_v;
            bus_b.sdo  = sdo_v;
            bus_b.lock = lock_v;
        end else begin
            bus_a.sclk = sclk_v;
            bus_a.sdo  = sdo_v;
            bus_a.lock = lock_v;
        end
    endtask

    // Shifts len bits of word MSB first; the 24-bit link carries inverted data on the pin.
    // rb collects sdi as the master sees it just before each of its sclk rises.
    task automatic send_bits(input bit sel, input int len, input logic [31:0] word,
                             output logic [31:0] rb);
        rb = '0;
        for (int i = len - 1; i >= 0; i--) begin
            drive(sel, 1'b0, word[i] ^ sel, 1'b0);
            repeat (H) @(negedge clk);
            rb = {rb[30:0], rd_sdi(sel)};
            drive(sel, 1'b1, word[i] ^ sel, 1'b0);
            repeat (H) @(negedge clk);
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
        repeat (H) @(negedge clk);
    endtask

    task automatic frame(input bit sel, input int len, input logic [31:0] word, input string tag);
        logic [31:0] rb;
        logic [31:0] exp_rb;
        logic [31:0] old;
        logic [31:0] d3;
        logic [31:0] d4;
        logic [31:0] mask;
        logic [8:0]  dv_m;
        logic [8:0]  fe_m;
        bit          good;
        int          w;
        w    = wid(sel);
        mask = (32'h1 << w) - 32'h1;
        good = (len == w);
        old  = applied[sel];
        send_bits(sel, len, word, rb);
        dv_m = '0;
        fe_m = '0;
        d3   = '0;
        d4   = '0;
        drive(sel, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            dv_m[k] = rd_dv(sel);
            fe_m[k] = rd_fe(sel);
            if (k == 3) d3 = rd_data(sel);
            if (k == 4) d4 = rd_data(sel);
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
        if (rb_ok[sel] && len > 0) begin
            exp_rb = (len <= w) ? (old >> (w - len)) : (old << (len - w));
            check({tag, "_readback"}, rb, exp_rb);
        end
        if (good) begin
            applied[sel] = word & mask;
            rb_ok[sel]   = 1'b1;
        end else if (len != 0) begin
            rb_ok[sel] = 1'b0;
        end
        // Pulses are expected only on the 4th clk after the lock pin rises.
        check({tag, "_dv"}, 32'(dv_m), good ? 32'h10 : 32'h0);
        check({tag, "_fe"}, 32'(fe_m), good ? 32'h0 : 32'h10);
        check({tag, "_hold"}, d3, old);
        check({tag, "_data"}, d4, applied[sel]);
    endtask

    initial begin
        logic [31:0] rb;
        int          len;
        int          r;
        int          streak;
        int          n_pulse;

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_data_in_reset", rd_data(0), 32'(DEF_A));
        aclr = 1'b0;

        n_pulse = 0;
        repeat (20) begin
            @(negedge clk);
            n_pulse += int'(rd_dv(0)) + int'(rd_fe(0)) + int'(rd_dv(1)) + int'(rd_fe(1));
        end
        check("rst_pulses", 32'(n_pulse), 32'h0);
        check("rst_data_a", rd_data(0), 32'(DEF_A));
        check("rst_data_b", rd_data(1), 32'(DEF_B));
        check("rst_sdi", 32'(rd_sdi(0)), 32'(DEF_A[15]));
        check("rst_timeout", 32'(rd_to(0)), 32'h0);

        frame(1'b0, 16, 32'hA5C3, "a5c3");
        frame(1'b0, 16, 32'h1234, "f1234");
        frame(1'b0, 15, $urandom, "len15");
        frame(1'b0, 17, $urandom, "len17");
        frame(1'b0, 16, 32'h0F0F, "after_err");
        frame(1'b0, 0, 32'h0, "len0");
        frame(1'b0, 16, $urandom, "after_len0");

        streak = 0;
        for (int n = 0; n < 30; n++) begin
            r   = int'($urandom_range(0, 9));
            len = (r < 5) ? 16 : (r == 5) ? 0 : (r == 6) ? 15 : (r == 7) ? 17
                : int'($urandom_range(1, 20));
            if (streak >= 3) len = 16;
            streak = (len == 16) ? 0 : streak + 1;
            frame(1'b0, len, $urandom, "rnd");
        end

        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        model_reset();
        check("sclr_data", rd_data(0), 32'(DEF_A));
        check("sclr_sdi", 32'(rd_sdi(0)), 32'(DEF_A[15]));
        check("sclr_timeout", 32'(rd_to(0)), 32'h0);
        frame(1'b0, 16, $urandom, "after_sclr");

        // Accept edge is 4 clk before frame() returns; expiry lands TO_A-1 clk after accept.
        frame(1'b0, 16, 32'hFFFF, "to_pre");
        repeat (TO_A - 6) @(negedge clk);
        check("to_flag_early", 32'(rd_to(0)), 32'h0);
        check("to_data_early", rd_data(0), 32'hFFFF);
        @(negedge clk);
        check("to_flag", 32'(rd_to(0)), 32'h1);
        check("to_data", rd_data(0), 32'(DEF_A));
        check("to_sdi", 32'(rd_sdi(0)), 32'(DEF_A[15]));
        check("to_no_dv", 32'(rd_dv(0)), 32'h0);
        applied[0] = 32'(DEF_A);
        rb_ok[0]   = 1'b1;
        frame(1'b0, 16, 32'h00FF, "to_clear");
        check("to_cleared", 32'(rd_to(0)), 32'h0);

        frame(1'b1, 24, 32'h123456, "inv24");
        frame(1'b1, 24, $urandom, "inv24_rb");
        frame(1'b1, 23, $urandom, "inv24_short");
        frame(1'b1, 24, $urandom, "inv24_again");

        send_bits(1'b0, 8, 32'hA7, rb);
        aclr = 1'b1;
        repeat (2) @(negedge clk);
        check("aclr_data", rd_data(0), 32'(DEF_A));
        aclr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        frame(1'b0, 16, 32'h5A5A, "post_aclr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
